dma_timing_ctrl: RTL

- Per-transfer sequencer and channel arbiter for the 8237A-style DMA datapath.
- Arbitrates unmasked DREQ lines and handshakes HRQ/HLDA with the CPU.
- Steps the S-state machine that drives IDLE_CYCLE/ACTIVE_CYCLE, AEN, ADSTB and the I/O and memory strobes consumed by the datapath.
- Holds per-channel current word counts and generates terminal count (TC) and EOP.

---
 rtl/dma_timing_ctrl_if.sv | 46 ++++
 rtl/dma_timing_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_timing_ctrl_if.sv
// Bus bundle between the DMA timing controller and its datapath/CPU side.
// The master side belongs to the controller, the slave side to the bus/datapath.
interface dma_timing_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]   DREQ;
  logic                HLDA;
  logic                EOP_N_IN;
  logic                CTRL_DISABLE;
  logic                ROT_PRIO;
  logic [NUM_CH-1:0]   CH_MASK;
  logic [2*NUM_CH-1:0] XFER_TYPE;
  logic [NUM_CH-1:0]   WC_LOAD;
  logic [CNT_W-1:0]    WC_DATA;

  logic                HRQ;
  logic [NUM_CH-1:0]   DACK;
  logic                AEN;
  logic                ADSTB;
  logic                IOR_N;
  logic                IOW_N;
  logic                MEMR_N;
  logic                MEMW_N;
  logic                EOP_N_OUT;
  logic                IDLE_CYCLE;
  logic                ACTIVE_CYCLE;
  logic                ADDR_INC;
  logic [CH_W-1:0]     ACT_CH;
  logic [NUM_CH-1:0]   TC_STATUS;

  modport master (
    input  DREQ, HLDA, EOP_N_IN, CTRL_DISABLE, ROT_PRIO, CH_MASK,
           XFER_TYPE, WC_LOAD, WC_DATA,
    output HRQ, DACK, AEN, ADSTB, IOR_N, IOW_N, MEMR_N, MEMW_N,
           EOP_N_OUT, IDLE_CYCLE, ACTIVE_CYCLE, ADDR_INC, ACT_CH, TC_STATUS
  );

  modport slave (
    output DREQ, HLDA, EOP_N_IN, CTRL_DISABLE, ROT_PRIO, CH_MASK,
           XFER_TYPE, WC_LOAD, WC_DATA,
    input  HRQ, DACK, AEN, ADSTB, IOR_N, IOW_N, MEMR_N, MEMW_N,
           EOP_N_OUT, IDLE_CYCLE, ACTIVE_CYCLE, ADDR_INC, ACT_CH, TC_STATUS
  );
endinterface

// File: rtl/dma_timing_ctrl.sv
// 8237A-style DMA sequencer: channel arbitration, HRQ/HLDA handshake, SI/S0/S1-S4 states,
// word counts and TC/EOP. Define DMA_DEMAND_MODE_EN for back-to-back demand transfers.
module dma_timing_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic           CLK,
  input logic           RESET,
  dma_timing_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_SI, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4
  } state_t;

  state_t state_q, state_d;

  logic              hrq_q, hrq_d;
  logic [NUM_CH-1:0] dack_q, dack_d;
  logic              aen_q, aen_d;
  logic              adstb_q, adstb_d;
  logic              ior_n_q, ior_n_d;
  logic              iow_n_q, iow_n_d;
  logic              memr_n_q, memr_n_d;
  logic              memw_n_q, memw_n_d;
  logic              eop_n_q, eop_n_d;
  logic              addr_inc_q, addr_inc_d;
  logic [CH_W-1:0]   act_ch_q, act_ch_d;
  logic [CH_W-1:0]   last_ch_q, last_ch_d;
  logic              eop_seen_q, eop_seen_d;
  logic [NUM_CH-1:0] tc_status_q, tc_status_d;

  logic [CNT_W-1:0]  wc_cnt [NUM_CH];

  logic [NUM_CH-1:0] valid_req;
  logic [1:0]        xfer_cur;
  logic              is_wr;
  logic              is_rd;
  logic              dec_en;
  logic              tc_hit;
  logic              demand_go;

  // Lowest index in fixed mode; in rotating mode the search starts just after
  // the last serviced channel.
  function automatic logic [CH_W-1:0] arb_pick(input logic [NUM_CH-1:0] req,
                                               input logic              rot,
                                               input logic [CH_W-1:0]   last);
    logic found;
    int   idx;
    arb_pick = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = rot ? ((int'(last) + 1 + i) % NUM_CH) : i;
      if (!found && req[idx]) begin
        arb_pick = CH_W'(idx);
        found    = 1'b1;
      end
    end
  endfunction

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    ch_onehot     = '0;
    ch_onehot[ch] = 1'b1;
  endfunction

  assign valid_req = bus.DREQ & ~bus.CH_MASK & {NUM_CH{~bus.CTRL_DISABLE}};
  assign xfer_cur  = bus.XFER_TYPE[2*act_ch_q +: 2];
  assign is_wr     = (xfer_cur == 2'b01);
  assign is_rd     = (xfer_cur == 2'b10);

`ifdef DMA_DEMAND_MODE_EN
  // Keep the bus while the serviced channel still requests and no TC/EOP ended it.
  assign demand_go = eop_n_q & bus.DREQ[act_ch_q] & ~bus.CH_MASK[act_ch_q];
`else
  assign demand_go = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hrq_d       = hrq_q;
    dack_d      = dack_q;
    aen_d       = aen_q;
    adstb_d     = 1'b0;
    ior_n_d     = 1'b1;
    iow_n_d     = 1'b1;
    memr_n_d    = 1'b1;
    memw_n_d    = 1'b1;
    eop_n_d     = 1'b1;
    addr_inc_d  = 1'b0;
    act_ch_d    = act_ch_q;
    last_ch_d   = last_ch_q;
    eop_seen_d  = eop_seen_q;
    tc_status_d = tc_status_q;
    dec_en      = 1'b0;
    tc_hit      = 1'b0;

    unique case (state_q)
      ST_SI: begin
        eop_seen_d = 1'b0;
        if (|valid_req) begin
          hrq_d   = 1'b1;
          state_d = ST_S0;
        end
      end

      ST_S0: begin
        if (~|valid_req) begin
          hrq_d   = 1'b0;
          state_d = ST_SI;
        end else if (bus.HLDA) begin
          act_ch_d = arb_pick(valid_req, bus.ROT_PRIO, last_ch_q);
          aen_d    = 1'b1;
          adstb_d  = 1'b1;
          state_d  = ST_S1;
        end
      end

      ST_S1: begin
        dack_d   = ch_onehot(act_ch_q);
        ior_n_d  = ~is_wr;
        memw_n_d = ~is_wr;
        memr_n_d = ~is_rd;
        iow_n_d  = ~is_rd;
        state_d  = ST_S2;
      end

      ST_S2: begin
        ior_n_d  = ~is_wr;
        memw_n_d = ~is_wr;
        memr_n_d = ~is_rd;
        iow_n_d  = ~is_rd;
        if (!bus.EOP_N_IN) eop_seen_d = 1'b1;
        state_d  = ST_S3;
      end

      // Count, TC and EOP are resolved on the edge into S4 from the pre-decrement count.
      ST_S3: begin
        dec_en     = 1'b1;
        addr_inc_d = 1'b1;
        tc_hit     = (wc_cnt[act_ch_q] == '0) | eop_seen_q | ~bus.EOP_N_IN;
        if (tc_hit) begin
          eop_n_d     = 1'b0;
          tc_status_d = tc_status_q | ch_onehot(act_ch_q);
        end
        state_d    = ST_S4;
      end

      ST_S4: begin
        eop_seen_d = 1'b0;
        if (demand_go) begin
          aen_d   = 1'b1;
          adstb_d = 1'b1;
          state_d = ST_S1;
        end else begin
          hrq_d     = 1'b0;
          aen_d     = 1'b0;
          dack_d    = '0;
          last_ch_d = act_ch_q;
          state_d   = ST_SI;
        end
      end

      default: state_d = ST_SI;
    endcase
  end

  // State and registered command outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_SI;
      hrq_q       <= 1'b0;
      dack_q      <= '0;
      aen_q       <= 1'b0;
      adstb_q     <= 1'b0;
      ior_n_q     <= 1'b1;
      iow_n_q     <= 1'b1;
      memr_n_q    <= 1'b1;
      memw_n_q    <= 1'b1;
      eop_n_q     <= 1'b1;
      addr_inc_q  <= 1'b0;
      act_ch_q    <= '0;
      last_ch_q   <= CH_W'(NUM_CH - 1);
      eop_seen_q  <= 1'b0;
      tc_status_q <= '0;
    end else begin
      state_q     <= state_d;
      hrq_q       <= hrq_d;
      dack_q      <= dack_d;
      aen_q       <= aen_d;
      adstb_q     <= adstb_d;
      ior_n_q     <= ior_n_d;
      iow_n_q     <= iow_n_d;
      memr_n_q    <= memr_n_d;
      memw_n_q    <= memw_n_d;
      eop_n_q     <= eop_n_d;
      addr_inc_q  <= addr_inc_d;
      act_ch_q    <= act_ch_d;
      last_ch_q   <= last_ch_d;
      eop_seen_q  <= eop_seen_d;
      tc_status_q <= tc_status_d;
    end
  end

  // Per-channel word counts; a host load beats the transfer decrement.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (RESET) begin
        wc_cnt[i] <= '0;
      end else if (bus.WC_LOAD[i]) begin
        wc_cnt[i] <= bus.WC_DATA;
      end else if (dec_en && (act_ch_q == CH_W'(i))) begin
        wc_cnt[i] <= wc_cnt[i] - 1'b1;
      end
    end
  end

  assign bus.HRQ          = hrq_q;
  assign bus.DACK         = dack_q;
  assign bus.AEN          = aen_q;
  assign bus.ADSTB        = adstb_q;
  assign bus.IOR_N        = ior_n_q;
  assign bus.IOW_N        = iow_n_q;
  assign bus.MEMR_N       = memr_n_q;
  assign bus.MEMW_N       = memw_n_q;
  assign bus.EOP_N_OUT    = eop_n_q;
  assign bus.ADDR_INC     = addr_inc_q;
  assign bus.ACT_CH       = act_ch_q;
  assign bus.TC_STATUS    = tc_status_q;
  assign bus.IDLE_CYCLE   = (state_q == ST_SI) || (state_q == ST_S0);
  assign bus.ACTIVE_CYCLE = !((state_q == ST_SI) || (state_q == ST_S0));

endmodule
